// File: rtl/store_narrow_rmw_pkg.sv
// Shared encodings for the narrow-store path: access sizes, FSM states and
// the alignment rule applied when a store request is accepted.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned one; size 11 never passes.
  function automatic logic store_is_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_narrow_rmw_if.sv
// Store request handshake plus the word-wide data memory port of the
// narrow-store block; slave is the block's view, master the requester/memory.
interface store_narrow_rmw_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        done;
  logic        err;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_rdata, mem_rvalid,
    output st_ready, done, err, mem_addr, mem_rd_en, mem_we, mem_wdata
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_rdata, mem_rvalid,
    input  st_ready, done, err, mem_addr, mem_rd_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops a byte or halfword into an existing word at
// the given byte offset, honouring the configured byte-lane order.
module store_lane_merge
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  output logic [31:0] new_word
);

  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    sh       = 5'd0;
    mask     = 32'h0;
    lane     = 32'h0;
    new_word = old_word;
    case (size)
      SZ_BYTE: begin
        // Big-endian offset 0 sits in the top byte, so the shift counts down.
        sh       = BIG_ENDIAN ? (5'd24 - {off, 3'b000}) : {off, 3'b000};
        mask     = 32'h0000_00FF << sh;
        lane     = {24'h0, data[7:0]} << sh;
        new_word = (old_word & ~mask) | lane;
      end
      SZ_HALF: begin
        sh       = BIG_ENDIAN ? (5'd16 - {off[1], 4'b0000}) : {off[1], 4'b0000};
        mask     = 32'h0000_FFFF << sh;
        lane     = {16'h0, data[15:0]} << sh;
        new_word = (old_word & ~mask) | lane;
      end
      SZ_WORD: new_word = data;
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrows a register value to byte/halfword/word and stores it into a memory
// without byte enables, using read-modify-write for sub-word stores.
module store_narrow_rmw
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  store_narrow_rmw_if.slave bus
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [31:0] merged;

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_word (bus.mem_rdata),
    .data     (data_q),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .new_word (merged)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          addr_d = bus.st_addr;
          data_d = bus.st_data;
          size_d = bus.st_size;
          if (!store_is_legal(bus.st_size, bus.st_addr[1:0])) begin
            state_d = ERR;
          end else if (bus.st_size == SZ_WORD) begin
            wdata_d = bus.st_data;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Read data arriving on the final allowed cycle still wins over the timeout.
        if (bus.mem_rvalid) begin
          wdata_d = merged;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) state_d = ERR;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.st_ready  = (state_q == IDLE);
    bus.mem_rd_en = (state_q == READ);
    bus.mem_we    = (state_q == WRITE);
    bus.done      = (state_q == DONE);
    bus.err       = (state_q == ERR);
    bus.mem_addr  = addr_q[31:2];
    bus.mem_wdata = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: a big-endian DUT (short timeout) and a
// little-endian DUT (default timeout) driven in lockstep against a byte-array model.
module tb_store_narrow_rmw;
  import mips_mem_pkg::*;

  localparam int TMO_BE = 4;
  localparam int TMO_LE = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  store_narrow_rmw_if if_be ();
  store_narrow_rmw_if if_le ();

  assign if_be.st_valid   = st_valid;
  assign if_be.st_addr    = st_addr;
  assign if_be.st_data    = st_data;
  assign if_be.st_size    = st_size;
  assign if_be.mem_rdata  = mem_rdata;
  assign if_be.mem_rvalid = mem_rvalid;
  assign if_le.st_valid   = st_valid;
  assign if_le.st_addr    = st_addr;
  assign if_le.st_data    = st_data;
  assign if_le.st_size    = st_size;
  assign if_le.mem_rdata  = mem_rdata;
  assign if_le.mem_rvalid = mem_rvalid;

  store_narrow_rmw #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYC(TMO_BE)) u_be (
    .clk(clk), .rst_n(rst_n), .bus(if_be.slave));
  store_narrow_rmw #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYC(TMO_LE)) u_le (
    .clk(clk), .rst_n(rst_n), .bus(if_le.slave));

  logic [1:0]  o_rdy, o_rd, o_we, o_done, o_err;
  logic [29:0] o_addr [2];
  logic [31:0] o_wd   [2];
  assign o_rdy  = {if_le.st_ready,  if_be.st_ready};
  assign o_rd   = {if_le.mem_rd_en, if_be.mem_rd_en};
  assign o_we   = {if_le.mem_we,    if_be.mem_we};
  assign o_done = {if_le.done,      if_be.done};
  assign o_err  = {if_le.err,       if_be.err};
  assign o_addr[0] = if_be.mem_addr;
  assign o_addr[1] = if_le.mem_addr;
  assign o_wd[0]   = if_be.mem_wdata;
  assign o_wd[1]   = if_le.mem_wdata;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h)", name, d, act, act, exp, exp);
    end
  endtask

  function automatic bit model_legal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b0;
    if (size == SZ_HALF && addr[0]) return 1'b0;
    if (size == SZ_WORD && addr[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // Memory word viewed as four bytes indexed by address offset.
  function automatic logic [31:0] model_merge(input bit be, input logic [31:0] old_w,
                                              input logic [31:0] data, input logic [1:0] off,
                                              input logic [1:0] size);
    logic [7:0]  b [4];
    logic [31:0] r;
    int o;
    o = int'(off);
    for (int k = 0; k < 4; k++) b[k] = be ? old_w[8*(3-k) +: 8] : old_w[8*k +: 8];
    if (size == SZ_WORD) return data;
    if (size == SZ_BYTE) b[o] = data[7:0];
    if (size == SZ_HALF) begin
      if (be) begin b[o] = data[15:8]; b[o+1] = data[7:0]; end
      else    begin b[o] = data[7:0];  b[o+1] = data[15:8]; end
    end
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (be) r[8*(3-k) +: 8] = b[k];
      else    r[8*k +: 8]     = b[k];
    end
    return r;
  endfunction

  // j = WAIT cycle (1-based) carrying mem_rvalid, 0 = never; spur adds a stray rvalid on cycle 1.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         input int j, input logic [31:0] rdata, input bit spur,
                         input bit [1:0] exp_err, input logic [31:0] wd_be, input logic [31:0] wd_le);
    int tmo [2];
    int e_err [2], e_done [2], e_we [2], e_rdn [2];
    int rd_n [2], rd_c [2], we_n [2], we_c [2], done_c [2], err_c [2];
    logic [31:0] wd [2];
    logic [29:0] wa [2];
    logic [31:0] e_wd [2];
    bit legal, sub;
    int last, waited;
    tmo[0] = TMO_BE; tmo[1] = TMO_LE;
    e_wd[0] = wd_be; e_wd[1] = wd_le;
    legal = model_legal(size, addr);
    sub   = (size == SZ_BYTE) || (size == SZ_HALF);
    last  = 1;
    for (int d = 0; d < 2; d++) begin
      e_rdn[d] = (legal && sub) ? 1 : 0;
      if (exp_err[d]) begin
        e_err[d] = legal ? tmo[d] + 2 : 1;
        e_done[d] = -1; e_we[d] = -1;
      end else if (size == SZ_WORD) begin
        e_err[d] = -1; e_we[d] = 1; e_done[d] = 2;
      end else begin
        e_err[d] = -1; e_we[d] = 2 + j; e_done[d] = 3 + j;
      end
      if (e_err[d] > last)  last = e_err[d];
      if (e_done[d] > last) last = e_done[d];
      rd_n[d] = 0; rd_c[d] = -1; we_n[d] = 0; we_c[d] = -1;
      done_c[d] = -1; err_c[d] = -1; wd[d] = 32'h0; wa[d] = 30'h0;
    end

    st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
    waited = 0;
    @(negedge clk);
    while (o_rdy != 2'b11 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", 0, waited, 0);
    @(posedge clk); #1;
    st_valid = 1'b0;
    st_data  = $urandom;

    for (int k = 1; k <= last; k++) begin
      mem_rvalid = (sub && j > 0 && k == 1 + j) || (spur && k == 1);
      mem_rdata  = (k == 1 + j) ? rdata : $urandom;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (o_rd[d]) begin rd_n[d]++; if (rd_c[d] < 0) rd_c[d] = k; end
        if (o_we[d]) begin
          we_n[d]++;
          if (we_c[d] < 0) begin we_c[d] = k; wd[d] = o_wd[d]; wa[d] = o_addr[d]; end
        end
        if (o_done[d] && done_c[d] < 0) done_c[d] = k;
        if (o_err[d]  && err_c[d]  < 0) err_c[d]  = k;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk("err_cycle",  d, err_c[d],  e_err[d]);
      chk("done_cycle", d, done_c[d], e_done[d]);
      chk("rd_count",   d, rd_n[d],   e_rdn[d]);
      chk("rd_cycle",   d, rd_c[d],   e_rdn[d] != 0 ? 1 : -1);
      chk("we_count",   d, we_n[d],   e_we[d] >= 0 ? 1 : 0);
      chk("we_cycle",   d, we_c[d],   e_we[d]);
      if (e_we[d] >= 0) begin
        chk("wdata",    d, wd[d], e_wd[d]);
        chk("mem_addr", d, wa[d], addr[31:2]);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"},  d, o_rdy[d],  1);
      chk({tag, "_rd"},     d, o_rd[d],   0);
      chk({tag, "_we"},     d, o_we[d],   0);
      chk({tag, "_done"},   d, o_done[d], 0);
      chk({tag, "_err"},    d, o_err[d],  0);
      chk({tag, "_addr"},   d, o_addr[d], 0);
      chk({tag, "_wdata"},  d, o_wd[d],   0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          j;
    logic [31:0] rdata;
    bit [1:0]    err;
    logic [31:0] wd_be;
    logic [31:0] wd_le;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'b00;
    mem_rdata = 32'h0; mem_rvalid = 1'b0;

    tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, SZ_WORD, 0, 32'h0,         2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1]  = '{32'h0000_0021, 32'h0000_00AB, SZ_BYTE, 3, 32'h1122_3344, 2'b00, 32'h11AB_3344, 32'h1122_AB44};
    tbl[2]  = '{32'h0000_0042, 32'h0000_CAFE, SZ_HALF, 1, 32'h1122_3344, 2'b00, 32'h1122_CAFE, 32'hCAFE_3344};
    tbl[3]  = '{32'h0000_0043, 32'h0000_CAFE, SZ_HALF, 1, 32'h1122_3344, 2'b11, 32'h0,         32'h0};
    tbl[4]  = '{32'h0000_0002, 32'h1234_5678, SZ_WORD, 0, 32'h0,         2'b11, 32'h0,         32'h0};
    tbl[5]  = '{32'h0000_0040, 32'h1234_5678, 2'b11,   1, 32'h0,         2'b11, 32'h0,         32'h0};
    tbl[6]  = '{32'h0000_0013, 32'h0000_005A, SZ_BYTE, 0, 32'h0,         2'b11, 32'h0,         32'h0};
    tbl[7]  = '{32'h0000_0013, 32'h0000_005A, SZ_BYTE, 4, 32'hA0B0_C0D0, 2'b00, 32'hA0B0_C05A, 32'h5AB0_C0D0};
    tbl[8]  = '{32'h0000_0013, 32'h0000_005A, SZ_BYTE, 5, 32'hA0B0_C0D0, 2'b01, 32'h0,         32'h5AB0_C0D0};
    tbl[9]  = '{32'h0000_0000, 32'h1234_BEEF, SZ_HALF, 2, 32'hFFFF_FFFF, 2'b00, 32'hBEEF_FFFF, 32'hFFFF_BEEF};
    tbl[10] = '{32'hFFFF_FFFC, 32'h0123_4567, SZ_WORD, 0, 32'h0,         2'b00, 32'h0123_4567, 32'h0123_4567};

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_txn(tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].j, tbl[i].rdata, 1'b1,
              tbl[i].err, tbl[i].wd_be, tbl[i].wd_le);

    // Reset dropped while a byte store waits for read data.
    st_valid = 1'b1; st_addr = 32'h0000_0105; st_data = 32'h0000_0077; st_size = SZ_BYTE;
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    begin
      int we_seen [2], other [2];
      for (int d = 0; d < 2; d++) begin we_seen[d] = 0; other[d] = 0; end
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (o_we[d]) we_seen[d]++;
          if (o_done[d] || o_err[d] || o_rd[d]) other[d]++;
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        chk("late_rvalid_we", d, we_seen[d], 0);
        chk("late_rvalid_pulses", d, other[d], 0);
      end
    end
    run_txn(32'h0000_0100, 32'hCAFE_F00D, SZ_WORD, 0, 32'h0, 1'b0, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr, data, rdata;
      logic [1:0]  size;
      int j, r;
      bit legal, sub, spur;
      bit [1:0] e;
      r = $urandom_range(0, 9);
      size = (r < 4) ? SZ_BYTE : (r < 7) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == SZ_HALF) addr[0] = 1'b0;
        if (size == SZ_WORD) addr[1:0] = 2'b00;
      end
      data  = $urandom;
      rdata = $urandom;
      j = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) j = 0;
      spur  = 1'($urandom_range(0, 1));
      legal = model_legal(size, addr);
      sub   = (size == SZ_BYTE) || (size == SZ_HALF);
      e[0]  = !legal || (sub && (j == 0 || j > TMO_BE));
      e[1]  = !legal || (sub && (j == 0 || j > TMO_LE));
      run_txn(addr, data, size, j, rdata, spur, e,
              model_merge(1'b1, rdata, data, addr[1:0], size),
              model_merge(1'b0, rdata, data, addr[1:0], size));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side counterpart of the load/immediate widening path. It narrows a 32-bit register value to a byte, halfword or word and writes it into a word-wide data memory that has no byte enables.
- Sub-word stores use a read-modify-write sequence. Word stores write directly.
- Sits between the datapath store request (stalling the pipeline through a ready/valid handshake) and the data memory port.

Parameters:
- BIG_ENDIAN, 1, byte-lane order: 1 means byte offset 0 is data[31:24]; 0 means byte offset 0 is data[7:0].
- TIMEOUT_CYC, 255, maximum cycles to wait for mem_rvalid before aborting with an error. Valid range is 1..255, held in an 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  block can accept a request; high only in IDLE.
- st_addr  in  32  byte address.
- st_data  in  32  register value to store; the low byte or halfword is used for sub-word stores.
- st_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- done  out  1  one-cycle pulse: the store completed.
- err  out  1  one-cycle pulse: misaligned or illegal request, or read timeout.
- mem_addr  out  30  word address, equal to the latched st_addr[31:2].
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data, qualified by mem_rvalid.
- mem_rvalid  in  1  read data valid.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  32  merged write word.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state goes to IDLE.
  - st_ready = 1; done, err, mem_rd_en and mem_we = 0; mem_addr, mem_wdata and internal registers = 0.
  - Reset mid-operation abandons the store with no write. A write strobe never extends past reset assertion.
- Accept: in IDLE, when st_valid && st_ready, latch addr, data and size.
- Legality is checked on the accept cycle:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - size 11 is always illegal.
- States:
  - IDLE: st_ready = 1. On accept, go to ERR if illegal, WRITE if word, READ if byte/halfword.
  - READ: mem_rd_en = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - When mem_rvalid = 1, capture mem_rdata, merge, and go to WRITE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC, go to ERR.
    - A mem_rvalid arriving in the same cycle the counter reaches TIMEOUT_CYC wins (data is accepted).
  - WRITE: mem_we = 1 for one cycle with mem_wdata; go to DONE.
  - DONE: done = 1 for one cycle; go to IDLE.
  - ERR: err = 1 for one cycle; no memory strobes; go to IDLE.
- mem_rvalid outside WAIT is ignored.
- Latency:
  - Word store: accept, WRITE, DONE, giving done 2 cycles after accept.
  - Sub-word store: accept, READ, WAIT (N cycles, N ≥ 1), WRITE, DONE.
  - Misaligned/illegal: err 1 cycle after accept.
- A back-to-back request is accepted on the cycle following DONE or ERR (IDLE).
- Merge (combinational), with off = addr[1:0]:
  - BIG_ENDIAN = 1: the byte lane for off k is bits [31-8k -: 8]; the halfword lane for off 0 is [31:16] and for off 2 is [15:0].
  - BIG_ENDIAN = 0: the byte lane for off k is [8k+7 -: 8]; the halfword lane for off 0 is [15:0] and for off 2 is [31:16].
  - Only the selected lane is replaced, by st_data[7:0] or st_data[15:0]. All other bits come from mem_rdata.
  - Word: mem_wdata = st_data, unmodified.
- mem_addr holds the latched word address from accept until the next accept.

Decomposition:
- Package mips_mem_pkg contains:
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - State enum IDLE/READ/WAIT/WRITE/DONE/ERR.
  - Default timeout constant.
- One natural sub-module: store_lane_merge. It is purely combinational, takes old_word, data, off, size and BIG_ENDIAN, and produces new_word. It is reusable by a future cache write path.

Test Plan:
- Word store, addr 0x0000_0010, data 0xDEADBEEF → no mem_rd_en; mem_we with mem_addr 0x4, wdata 0xDEADBEEF; done 2 cycles after accept.
- Byte store BIG_ENDIAN = 1, addr 0x21, data 0x0000_00AB, rdata 0x11223344 after 3 wait cycles → wdata 0x11AB3344; mem_addr 0x8; done the cycle after mem_we.
- Halfword store BIG_ENDIAN = 0, addr 0x42, data 0x0000_CAFE, rdata 0x11223344 → wdata 0xCAFE3344.
- Misaligned halfword addr 0x43, and word addr 0x02, and size 11 → err pulse 1 cycle after accept; no mem_rd_en/mem_we; st_ready high the next cycle.
- TIMEOUT_CYC = 4, byte store, mem_rvalid never asserted → err after 4 WAIT cycles; no mem_we. A repeat run with rvalid on the 4th cycle → write proceeds.
- rst_n dropped during WAIT of a byte store → outputs return to reset values immediately; a later late mem_rvalid produces no mem_we; a next word store completes normally.
